// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between the requesters and the
// 8-way round-robin arbiter.
//   req       requester -> arbiter, bit k = requester k wants the resource
//   done      requester -> arbiter, one-cycle release pulse from the owner
//   gnt       arbiter -> requester, registered one-hot grant
//   gnt_id    arbiter -> requester, registered binary index of the owner
//   gnt_valid arbiter -> requester, high while any grant is asserted
//   timeout   arbiter -> requester, one-cycle pulse marking a forced release
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  // Requester side drives requests and release.
  modport master (
    output req, done,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, done,
    output gnt, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-requester round-robin arbiter with registered grants.
// The first asserted request at or after a rotating pointer wins; the grant
// is held until the owner pulses done, drops its request, or has held the
// grant for MAX_HOLD cycles (forced release, flagged by a timeout pulse).
// Every release is followed by at least one cycle with no grant.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rr_arbiter8_if.slave (req, done in; gnt, gnt_id, gnt_valid, timeout out)
// Parameter:
//   MAX_HOLD  maximum grant length in cycles (0..255, 0 disables the timeout)
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter8_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  localparam logic       HOLD_EN  = (MAX_HOLD != 0);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic [7:0] gnt_q, gnt_nxt;
  logic [2:0] id_q, id_nxt;
  logic       tmo_q, tmo_nxt;
  logic [3:0] win;  // {found, index}

  // Rotating-priority encode: scan offsets high to low so the smallest
  // offset from the pointer is the last write and therefore wins.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] k;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      k = p + 3'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  assign win = pick(bus.req, ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      hold_cnt <= 8'd0;
      gnt_q    <= 8'h00;
      id_q     <= 3'd0;
      tmo_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
      gnt_q    <= gnt_nxt;
      id_q     <= id_nxt;
      tmo_q    <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = gnt_q;
    id_nxt       = id_q;
    tmo_nxt      = 1'b0;
    case (state)
      IDLE: begin
        // done is deliberately ignored here; only requests start a grant.
        if (win[3]) begin
          state_nxt    = GRANT;
          gnt_nxt      = 8'b1 << win[2:0];
          id_nxt       = win[2:0];
          hold_cnt_nxt = 8'd1;
        end
      end
      GRANT: begin
        // Normal release outranks the timeout, so done on the last allowed
        // cycle releases without a timeout pulse. Other req bits are not
        // looked at while a grant is held.
        if (bus.done || !bus.req[id_q]) begin
          state_nxt    = IDLE;
          gnt_nxt      = 8'h00;
          ptr_nxt      = id_q + 3'd1;
          hold_cnt_nxt = 8'd0;
        end else if (HOLD_EN && hold_cnt == HOLD_LIM) begin
          state_nxt    = IDLE;
          gnt_nxt      = 8'h00;
          ptr_nxt      = id_q + 3'd1;
          hold_cnt_nxt = 8'd0;
          tmo_nxt      = 1'b1;
        end else if (hold_cnt != 8'hFF) begin
          // Saturates only when the timeout is disabled.
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt       = gnt_q;
    bus.gnt_id    = id_q;
    bus.gnt_valid = |gnt_q;
    bus.timeout   = tmo_q;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter that shares one resource (e.g. the downstream datapath behind the priority-encoded select) between requesters.
- Uses a rotating-priority encode: the first asserted request at or after a rotating pointer wins.
- Grants are registered, held until release, and bounded by an optional hold timeout.
- Outputs a one-hot grant plus the binary 3-bit grant index for the shared datapath select.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may stay asserted. Legal range 0..255; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit k = requester k.
- done  input  1  single-cycle release pulse from the current owner.
- gnt  output  8  one-hot grant, registered.
- gnt_id  output  3  binary index of the granted requester, registered.
- gnt_valid  output  1  high while any grant is asserted; equals |gnt.
- timeout  output  1  one-cycle pulse, registered, marking a forced release.

Behaviour:
- Reset (sync, clk edge with rst=1) values:
  - gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0.
  - Internal state: state=IDLE, ptr=3'd0, hold_cnt=8'd0.
  - rst overrides all other inputs.
- State machine: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE and keep all outputs at their reset values, except that timeout may still show a pulse from the previous cycle.
  - If req!=0, select winner w = first k in the order ptr, ptr+1, ..., ptr+7 (mod 8) with req[k]=1.
  - Next edge: gnt=1<<w, gnt_id=w, gnt_valid=1, hold_cnt=1, state=GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
- GRANT: at each edge, evaluate in this priority order.
  1. done=1 or req[gnt_id]=0 → normal release. Next cycle: gnt=0, gnt_valid=0, timeout=0, state=IDLE, ptr=(gnt_id+1) mod 8.
  2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD → forced release. Same as normal release, but timeout=1 for exactly one cycle.
  3. Otherwise, hold the grant and set hold_cnt=hold_cnt+1. Width is 8 bits; it cannot exceed MAX_HOLD. With MAX_HOLD=0, hold_cnt saturates at 255.
- Max grant width: gnt is high at most MAX_HOLD consecutive cycles.
- Dead cycle: every release is followed by at least one cycle with gnt=0. There are no back-to-back grants, so the minimum period between grants is 2 cycles.
- Pointer:
  - Updates only on release.
  - Wraps 7→0.
  - Is not changed by requests arriving or dropping while in IDLE.
- Simultaneous events:
  - done together with the timeout condition → normal release, timeout=0.
  - done sampled in IDLE is ignored.
  - Changes to req bits other than req[gnt_id] during GRANT have no effect.
- gnt_id holds its last value after release. It is only meaningful while gnt_valid=1.
- Reset mid-grant: the next edge clears gnt and timeout and sets ptr=0. Arbitration restarts from requester 0.
- Invariants, every cycle:
  - gnt is zero or one-hot.
  - When gnt_valid=1, gnt==(1<<gnt_id).
  - timeout=1 implies gnt_valid=0.

Test Plan:
- Reset then basic order: rst 2 cycles, req=8'b00000101 held, done pulse every grant.
  - → gnt=8'h01 (id0) one cycle after req.
  - → after done: one dead cycle, then gnt=8'h04 (id2), then id0 again.
- Fairness/rotation: req=8'hFF held, done pulsed on the 3rd cycle of each grant.
  - → gnt_id sequence 0,1,2,3,4,5,6,7,0.
  - → each grant lasts 3 cycles, with one idle cycle between grants.
- Wrap-around: grant id7 released by done, then req=8'h81.
  - → next grant is id0 (ptr wrapped to 0), not id7.
- Timeout (MAX_HOLD=16): req=8'h08 held, done never asserted.
  - → gnt=8'h08 for exactly 16 cycles.
  - → timeout=1 for 1 cycle with gnt=0.
  - → gnt=8'h08 re-asserted on the following cycle.
  - Same stimulus with done on cycle 16 → timeout stays 0.
- Request withdrawal: grant id4 active, req[4] dropped while req[6]=1.
  - → gnt=0 on the next cycle, timeout=0.
  - → then gnt=8'h40 (id6).
- Reset mid-grant: grant id5 active, assert rst 1 cycle with req=8'hFF.
  - → gnt=0 and timeout=0 after the edge.
  - → first grant after rst deasserts is id0.
